// File: rtl/uinstr_addr_seq.sv
// uinstr_addr_seq: operand-address sequencer between the micro-instruction issue stage and the
// vector register file read port. One micro-instruction is latched per handshake. Its enabled
// sources are issued as valid/ready read-address beats in ascending order, followed by an
// optional addr+1 beat for a register pair. The opcode is then pushed downstream.
//
// Optional feature macro: UINSTR_ADDR_SEQ_SKIP_EN
//   defined   - uinstr_src_en_i selects which sources are issued; an empty mask goes straight
//               to the opcode push.
//   undefined - uinstr_src_en_i is ignored and every source is issued.
module uinstr_addr_seq #(
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned OPCODE_W = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      uinstr_valid_i,
  output logic                      uinstr_ready_o,
  input  logic [OPCODE_W-1:0]       uinstr_opcode_i,
  input  logic [NUM_SRC*ADDR_W-1:0] uinstr_src_i,
  input  logic [NUM_SRC-1:0]        uinstr_src_en_i,
  input  logic                      uinstr_pair_i,
  output logic                      rd_addr_valid_o,
  input  logic                      rd_addr_ready_i,
  output logic [ADDR_W-1:0]         rd_addr_o,
  output logic                      rd_addr_last_o,
  output logic                      op_valid_o,
  input  logic                      op_ready_i,
  output logic [OPCODE_W-1:0]       op_o,
  output logic                      busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_SRC + 2);
  // Beat index value reserved for the trailing register-pair beat.
  localparam logic [IdxW-1:0] PairIdx = IdxW'(NUM_SRC);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StPush  = 2'd2;

  logic [1:0]                          state_q, state_d;
  logic [OPCODE_W-1:0]                 op_q, op_d;
  logic [NUM_SRC-1:0][ADDR_W-1:0]      src_q, src_d;
  logic [NUM_SRC-1:0]                  mask_q, mask_d;
  logic                                pair_q, pair_d;
  logic [IdxW-1:0]                     idx_q, idx_d;

  logic [NUM_SRC-1:0] eff_mask;
  logic [ADDR_W-1:0]  sel_addr;
  logic [ADDR_W-1:0]  last_addr;
  logic [ADDR_W-1:0]  beat_addr;
  logic [IdxW-1:0]    next_idx;
  logic               is_pair_beat;
  logic               beat_last;

`ifdef UINSTR_ADDR_SEQ_SKIP_EN
  assign eff_mask = uinstr_src_en_i;
`else
  assign eff_mask = '1;
  logic unused_src_en;
  assign unused_src_en = ^uinstr_src_en_i;
`endif

  // Lowest enabled source index at or above 'from'; PairIdx when none is left.
  function automatic logic [IdxW-1:0] first_en(input logic [NUM_SRC-1:0] m,
                                               input logic [IdxW-1:0]    from);
    logic [IdxW-1:0] r;
    r = PairIdx;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (m[k] && (IdxW'(k) >= from)) r = IdxW'(k);
    end
    return r;
  endfunction

  // Decode the current beat's address and last flag from the latched instruction.
  always_comb begin
    sel_addr  = '0;
    last_addr = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (idx_q == IdxW'(k)) sel_addr = src_q[k];
      if (mask_q[k])         last_addr = src_q[k];
    end
    next_idx     = first_en(mask_q, idx_q + IdxW'(1));
    is_pair_beat = (idx_q == PairIdx);
    // Pair address wraps naturally at ADDR_W bits.
    beat_addr    = is_pair_beat ? (last_addr + ADDR_W'(1)) : sel_addr;
    beat_last    = is_pair_beat | (~pair_q & (next_idx == PairIdx));
  end

  // Next-state logic for the IDLE -> ISSUE -> PUSH sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    mask_d  = mask_q;
    pair_d  = pair_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (uinstr_valid_i) begin
          op_d   = uinstr_opcode_i;
          src_d  = uinstr_src_i;
          mask_d = eff_mask;
          // A pair bit on an empty mask produces no beats at all.
          pair_d = uinstr_pair_i & (|eff_mask);
          idx_d  = first_en(eff_mask, '0);
          state_d = (|eff_mask) ? StIssue : StPush;
        end
      end
      StIssue: begin
        if (rd_addr_ready_i) begin
          idx_d = next_idx;
          if (beat_last) state_d = StPush;
        end
      end
      StPush: begin
        if (op_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and instruction latches; asynchronous reset discards any in-flight instruction.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= StIdle;
      op_q    <= '0;
      src_q   <= '0;
      mask_q  <= '0;
      pair_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      mask_q  <= mask_d;
      pair_q  <= pair_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    uinstr_ready_o  = (state_q == StIdle);
    busy_o          = (state_q != StIdle);
    rd_addr_valid_o = (state_q == StIssue);
    rd_addr_o       = rd_addr_valid_o ? beat_addr : '0;
    rd_addr_last_o  = rd_addr_valid_o & beat_last;
    op_valid_o      = (state_q == StPush);
    op_o            = op_valid_o ? op_q : '0;
  end

endmodule
